// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute bundle (forwarding sources under ID_EX_FORWARD_EN)
interface id_ex_stage_if #(parameter int XLEN = 32);
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic            id_funct7_5;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [4:0]      id_rd;
  logic            stall;
  logic            flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [3:0]      ex_alu_ctrl;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
`ifdef ID_EX_FORWARD_EN
  logic [4:0]      mem_rd;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [4:0]      wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_result;
`endif

  modport master (
`ifdef ID_EX_FORWARD_EN
    output mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
`endif
    output id_valid, id_opcode, id_funct3, id_funct7_5, id_rs1_addr, id_rs2_addr,
    output id_rs1_data, id_rs2_data, id_imm, id_rd, stall, flush,
    input  ex_valid, ex_rs1, ex_rs2, ex_alu_ctrl, ex_rd, ex_reg_write
  );

  modport slave (
`ifdef ID_EX_FORWARD_EN
    input  mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_result,
`endif
    input  id_valid, id_opcode, id_funct3, id_funct7_5, id_rs1_addr, id_rs2_addr,
    input  id_rs1_data, id_rs2_data, id_imm, id_rd, stall, flush,
    output ex_valid, ex_rs1, ex_rs2, ex_alu_ctrl, ex_rd, ex_reg_write
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with ALU decode; ID_EX_FORWARD_EN adds MEM/WB operand forwarding
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;

  logic [3:0]      dec_alu;
  logic            dec_use_imm;
  logic            dec_reg_write;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b_reg;

  // alt selects SUB/SRA; the I-type caller only passes it through for shifts
  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_map = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_map = ALU_SLL;
      3'b010:  alu_map = ALU_SLT;
      3'b011:  alu_map = ALU_SLTU;
      3'b100:  alu_map = ALU_XOR;
      3'b101:  alu_map = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_map = ALU_OR;
      default: alu_map = ALU_AND;
    endcase
  endfunction

  always_comb begin
    dec_alu       = ALU_NONE;
    dec_use_imm   = 1'b0;
    dec_reg_write = 1'b0;
    case (bus.id_opcode)
      OP_R: begin
        dec_alu       = alu_map(bus.id_funct3, bus.id_funct7_5);
        dec_reg_write = (bus.id_rd != 5'd0);
      end
      OP_I: begin
        dec_alu       = alu_map(bus.id_funct3, bus.id_funct7_5 && (bus.id_funct3 == 3'b101));
        dec_use_imm   = 1'b1;
        dec_reg_write = (bus.id_rd != 5'd0);
      end
      OP_LOAD: begin
        dec_alu       = ALU_ADD;
        dec_use_imm   = 1'b1;
        dec_reg_write = (bus.id_rd != 5'd0);
      end
      OP_STORE: begin
        dec_alu       = ALU_ADD;
        dec_use_imm   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef ID_EX_FORWARD_EN
  // MEM is younger than WB, so it wins when both target the same register
  function automatic logic [XLEN-1:0] fwd(
    input logic [4:0]      src,
    input logic [XLEN-1:0] rf_data,
    input logic            m_we,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_res,
    input logic            w_we,
    input logic [4:0]      w_rd,
    input logic [XLEN-1:0] w_res
  );
    if (m_we && (m_rd != 5'd0) && (m_rd == src))      fwd = m_res;
    else if (w_we && (w_rd != 5'd0) && (w_rd == src)) fwd = w_res;
    else                                              fwd = rf_data;
  endfunction

  always_comb begin
    op_a     = fwd(bus.id_rs1_addr, bus.id_rs1_data, bus.mem_reg_write, bus.mem_rd,
                   bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_result);
    op_b_reg = fwd(bus.id_rs2_addr, bus.id_rs2_data, bus.mem_reg_write, bus.mem_rd,
                   bus.mem_result, bus.wb_reg_write, bus.wb_rd, bus.wb_result);
  end
`else
  logic unused_src_addr;
  assign unused_src_addr = ^{bus.id_rs1_addr, bus.id_rs2_addr};

  always_comb begin
    op_a     = bus.id_rs1_data;
    op_b_reg = bus.id_rs2_data;
  end
`endif

  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    alu_ctrl_d  = alu_ctrl_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    if (bus.flush || (!bus.stall && !bus.id_valid)) begin
      valid_d     = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      alu_ctrl_d  = ALU_NONE;
      rd_d        = 5'd0;
      reg_write_d = 1'b0;
    end else if (!bus.stall) begin
      valid_d     = 1'b1;
      rs1_d       = op_a;
      rs2_d       = dec_use_imm ? bus.id_imm : op_b_reg;
      alu_ctrl_d  = dec_alu;
      rd_d        = bus.id_rd;
      reg_write_d = dec_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      alu_ctrl_q  <= ALU_NONE;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_rs1       = rs1_q;
  assign bus.ex_rs2       = rs2_q;
  assign bus.ex_alu_ctrl  = alu_ctrl_q;
  assign bus.ex_rd        = rd_q;
  assign bus.ex_reg_write = reg_write_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed bench for id_ex_stage (forwarding steps under ID_EX_FORWARD_EN)
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rd);
    bus.id_valid    = v;
    bus.id_opcode   = op;
    bus.id_funct3   = f3;
    bus.id_funct7_5 = f7;
    bus.id_rs1_data = a;
    bus.id_rs2_data = b;
    bus.id_imm      = imm;
    bus.id_rd       = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, 32'(bus.ex_valid), 32'd0);
    check({tag, "_rw"},    32'(bus.ex_reg_write), 32'd0);
    check({tag, "_alu"},   32'(bus.ex_alu_ctrl), 32'hF);
    check({tag, "_rs1"},   bus.ex_rs1, 32'd0);
    check({tag, "_rs2"},   bus.ex_rs2, 32'd0);
    check({tag, "_rd"},    32'(bus.ex_rd), 32'd0);
  endtask

  initial begin
    bus.stall       = 1'b1;
    bus.flush       = 1'b1;
    bus.id_rs1_addr = 5'd1;
    bus.id_rs2_addr = 5'd2;
`ifdef ID_EX_FORWARD_EN
    bus.mem_rd        = 5'd0;
    bus.mem_reg_write = 1'b0;
    bus.mem_result    = 32'd0;
    bus.wb_rd         = 5'd0;
    bus.wb_reg_write  = 1'b0;
    bus.wb_result     = 32'd0;
`endif
    drive(1'b1, 7'b0110011, 3'b111, 1'b0, 32'hDEADBEEF, 32'h1, 32'h2, 5'd7);
    step();
    check_bubble("reset");

    rst = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b1, 7'b0110011, 3'b111, 1'b0, 32'hA5A5F0F0, 32'h0F0FA5A5, 32'h0, 5'd3);
    step();
    check("and_alu",   32'(bus.ex_alu_ctrl), 32'h2);
    check("and_rs1",   bus.ex_rs1, 32'hA5A5F0F0);
    check("and_rs2",   bus.ex_rs2, 32'h0F0FA5A5);
    check("and_valid", 32'(bus.ex_valid), 32'd1);
    check("and_rw",    32'(bus.ex_reg_write), 32'd1);
    check("and_rd",    32'(bus.ex_rd), 32'd3);

    drive(1'b1, 7'b0010011, 3'b110, 1'b0, 32'h1, 32'h12345678, 32'hFFFF0000, 5'd4);
    step();
    check("ori_alu", 32'(bus.ex_alu_ctrl), 32'h3);
    check("ori_rs2", bus.ex_rs2, 32'hFFFF0000);
    check("ori_rw",  32'(bus.ex_reg_write), 32'd1);

    drive(1'b1, 7'b0110011, 3'b000, 1'b1, 32'h5, 32'h6, 32'h0, 5'd8);
    step();
    check("sub_alu", 32'(bus.ex_alu_ctrl), 32'h1);
    drive(1'b1, 7'b0010011, 3'b000, 1'b1, 32'h5, 32'h6, 32'h9, 5'd8);
    step();
    check("addi_f7_alu", 32'(bus.ex_alu_ctrl), 32'h0);
    drive(1'b1, 7'b0010011, 3'b101, 1'b1, 32'h5, 32'h6, 32'h3, 5'd8);
    step();
    check("srai_alu", 32'(bus.ex_alu_ctrl), 32'h7);
    drive(1'b1, 7'b0110011, 3'b101, 1'b0, 32'h5, 32'h6, 32'h0, 5'd8);
    step();
    check("srl_alu", 32'(bus.ex_alu_ctrl), 32'h6);
    drive(1'b1, 7'b0110011, 3'b011, 1'b0, 32'h5, 32'h6, 32'h0, 5'd8);
    step();
    check("sltu_alu", 32'(bus.ex_alu_ctrl), 32'h9);
    drive(1'b1, 7'b0110011, 3'b010, 1'b0, 32'h5, 32'h6, 32'h0, 5'd8);
    step();
    check("slt_alu", 32'(bus.ex_alu_ctrl), 32'h8);

    drive(1'b1, 7'b0110011, 3'b100, 1'b0, 32'h11111111, 32'h22222222, 32'h0, 5'd5);
    step();
    check("xor_alu", 32'(bus.ex_alu_ctrl), 32'h4);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'h33333333 + i, 32'h44444444, 32'h0, 5'd9);
      step();
      check("stall_alu",   32'(bus.ex_alu_ctrl), 32'h4);
      check("stall_rs1",   bus.ex_rs1, 32'h11111111);
      check("stall_rs2",   bus.ex_rs2, 32'h22222222);
      check("stall_rd",    32'(bus.ex_rd), 32'd5);
      check("stall_valid", 32'(bus.ex_valid), 32'd1);
    end
    bus.flush = 1'b1;
    step();
    check_bubble("stall_flush");
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'h1, 32'h2, 32'h0, 5'd0);
    step();
    check("rd0_rw",    32'(bus.ex_reg_write), 32'd0);
    check("rd0_valid", 32'(bus.ex_valid), 32'd1);
    drive(1'b1, 7'b1100011, 3'b000, 1'b0, 32'h1, 32'h2, 32'h10, 5'd6);
    step();
    check("branch_alu",   32'(bus.ex_alu_ctrl), 32'hF);
    check("branch_rw",    32'(bus.ex_reg_write), 32'd0);
    check("branch_valid", 32'(bus.ex_valid), 32'd1);

    drive(1'b1, 7'b0000011, 3'b010, 1'b0, 32'h1000, 32'h7, 32'h24, 5'd10);
    step();
    check("load_alu", 32'(bus.ex_alu_ctrl), 32'h0);
    check("load_rs2", bus.ex_rs2, 32'h24);
    check("load_rw",  32'(bus.ex_reg_write), 32'd1);
    drive(1'b1, 7'b0100011, 3'b010, 1'b0, 32'h1000, 32'h7, 32'h28, 5'd10);
    step();
    check("store_alu", 32'(bus.ex_alu_ctrl), 32'h0);
    check("store_rs2", bus.ex_rs2, 32'h28);
    check("store_rw",  32'(bus.ex_reg_write), 32'd0);

    drive(1'b0, 7'b0110011, 3'b111, 1'b0, 32'hFF, 32'hEE, 32'h0, 5'd11);
    step();
    check_bubble("invalid");

`ifdef ID_EX_FORWARD_EN
    bus.id_rs1_addr   = 5'd5;
    bus.id_rs2_addr   = 5'd5;
    bus.mem_rd        = 5'd5;
    bus.mem_reg_write = 1'b1;
    bus.mem_result    = 32'h11112222;
    bus.wb_rd         = 5'd5;
    bus.wb_reg_write  = 1'b1;
    bus.wb_result     = 32'h33334444;
    drive(1'b1, 7'b0110011, 3'b000, 1'b0, 32'hAAAA0000, 32'hBBBB0000, 32'h0, 5'd12);
    step();
    check("fwd_mem_rs1", bus.ex_rs1, 32'h11112222);
    check("fwd_mem_rs2", bus.ex_rs2, 32'h11112222);
    bus.mem_rd = 5'd0;
    step();
    check("fwd_wb_rs1", bus.ex_rs1, 32'h33334444);
    drive(1'b1, 7'b0010011, 3'b000, 1'b0, 32'hAAAA0000, 32'hBBBB0000, 32'h77, 5'd12);
    step();
    check("fwd_imm_rs2", bus.ex_rs2, 32'h77);
    bus.mem_reg_write = 1'b0;
    bus.wb_reg_write  = 1'b0;
    bus.id_rs1_addr   = 5'd1;
    bus.id_rs2_addr   = 5'd2;
`endif

    drive(1'b1, 7'b0110011, 3'b110, 1'b0, 32'h12121212, 32'h34343434, 32'h0, 5'd13);
    step();
    check("pre_rst_alu", 32'(bus.ex_alu_ctrl), 32'h3);
    bus.stall = 1'b1;
    step();
    check("pre_rst_hold", bus.ex_rs1, 32'h12121212);
    rst = 1'b1;
    step();
    check_bubble("rst_in_stall");
    rst = 1'b0;
    bus.stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
